// File: rtl/iir_pkg.sv
// Shared definitions for the SOS cascade: coefficient slot indices, FSM and
// MAC-op enums, and the round/saturate helpers used by the datapath.
package iir_pkg;

    // Coefficient slots within one section; address = stage*N_COEF + idx.
    localparam int N_COEF   = 6;
    localparam int IDX_GAIN = 0;
    localparam int IDX_B0   = 1;
    localparam int IDX_B1   = 2;
    localparam int IDX_B2   = 3;
    localparam int IDX_A1   = 4;
    localparam int IDX_A2   = 5;

    // Width used for round/saturate arithmetic; wide enough for any accumulator.
    localparam int CALC_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        GAIN,
        MAC,
        UPDATE,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MAC_HOLD,
        MAC_LOAD,
        MAC_ADD,
        MAC_SUB
    } mac_op_t;

    // Value of 1.0 in Q1.(coef_size-2).
    function automatic int coef_one(input int coef_size);
        return 1 << (coef_size - 2);
    endfunction

    // 1.0 for the default 20-bit coefficient format.
    localparam int COEF_ONE = 1 << 18;

    // Round half up, then drop the fractional bits.
    function automatic logic signed [CALC_W-1:0] rnd(input logic signed [CALC_W-1:0] v,
                                                     input int frac_bits);
        logic signed [CALC_W-1:0] half;
        half = 64'sd1 <<< (frac_bits - 1);
        return (v + half) >>> frac_bits;
    endfunction

    // Clamp to the signed range of a data_bits-wide sample.
    function automatic logic signed [CALC_W-1:0] sat(input logic signed [CALC_W-1:0] v,
                                                     input int data_bits);
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (64'sd1 <<< (data_bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_bits - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/iir_sos_cascade_if.sv
// Sample/coefficient bus of the SOS cascade. The source/host side uses the
// master modport, the filter uses the slave modport.
interface iir_sos_cascade_if #(
    parameter int DATA_SIZE = 24,
    parameter int COEF_SIZE = 20,
    parameter int ADDR_W    = 7
);
    logic signed [DATA_SIZE-1:0] data_in;
    logic                        sample_trig;
    logic signed [DATA_SIZE-1:0] data_out;
    logic                        filter_done;
    logic                        busy;
    logic                        overrun;
    logic                        coef_we;
    logic [ADDR_W-1:0]           coef_addr;
    logic signed [COEF_SIZE-1:0] coef_wdata;

    modport master (
        output data_in, sample_trig, coef_we, coef_addr, coef_wdata,
        input  data_out, filter_done, busy, overrun
    );

    modport slave (
        input  data_in, sample_trig, coef_we, coef_addr, coef_wdata,
        output data_out, filter_done, busy, overrun
    );
endinterface

// File: rtl/sos_mac.sv
// Shared multiply-accumulate unit: one signed product per cycle, accumulator
// with load/add/subtract, and a rounded + saturated view of the accumulator.
module sos_mac
    import iir_pkg::*;
#(
    parameter int DATA_SIZE = 24,
    parameter int COEF_SIZE = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  mac_op_t                     op,
    input  logic signed [DATA_SIZE-1:0] data,
    input  logic signed [COEF_SIZE-1:0] coef,
    output logic signed [DATA_SIZE-1:0] result
);
    localparam int PROD_W = DATA_SIZE + COEF_SIZE;
    // Three guard bits cover the five-term sum without wrapping.
    localparam int ACC_W  = PROD_W + 3;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [CALC_W-1:0] acc_wide;

    assign prod     = PROD_W'(data) * PROD_W'(coef);
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign acc_wide = {{(CALC_W - ACC_W){acc_reg[ACC_W-1]}}, acc_reg};
    assign result   = DATA_SIZE'(sat(rnd(acc_wide, COEF_SIZE - 2), DATA_SIZE));

    // Accumulator: load starts a new sum, add/sub fold in the current product.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
        end else begin
            case (op)
                MAC_LOAD: acc_reg <= prod_ext;
                MAC_ADD:  acc_reg <= acc_reg + prod_ext;
                MAC_SUB:  acc_reg <= acc_reg - prod_ext;
                default:  acc_reg <= acc_reg;
            endcase
        end
    end
endmodule

// File: rtl/iir_sos_cascade.sv
// Cascade of N_STAGES Direct Form I biquads sharing one MAC. Each stage takes
// 7 cycles (GAIN, 5x MAC, UPDATE); the last stage's output is published in DONE.
module iir_sos_cascade
    import iir_pkg::*;
#(
    parameter int COEF_SIZE = 20,
    parameter int DATA_SIZE = 24,
    parameter int N_STAGES  = 4,
    parameter int ADDR_W    = 7
) (
    input logic               clk,
    input logic               reset,
    iir_sos_cascade_if.slave  bus
);
    localparam int N_COEFS = N_COEF * N_STAGES;
    localparam int STAGE_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int CIDX_W  = $clog2(N_COEFS);

    state_t                      state_reg;
    logic [STAGE_W-1:0]          stage_reg;
    logic [2:0]                  idx_reg;
    logic signed [DATA_SIZE-1:0] u_reg;
    logic signed [DATA_SIZE-1:0] x_cur_reg;
    logic signed [DATA_SIZE-1:0] data_out_reg;
    logic                        filter_done_reg;
    logic                        busy_reg;
    logic                        overrun_reg;

    logic signed [COEF_SIZE-1:0] coef_arr [N_COEFS];
    logic signed [DATA_SIZE-1:0] x1_arr [N_STAGES];
    logic signed [DATA_SIZE-1:0] x2_arr [N_STAGES];
    logic signed [DATA_SIZE-1:0] y1_arr [N_STAGES];
    logic signed [DATA_SIZE-1:0] y2_arr [N_STAGES];

    mac_op_t                     mac_op;
    logic [2:0]                  coef_sel;
    logic [CIDX_W-1:0]           coef_idx;
    logic signed [COEF_SIZE-1:0] coef_rd;
    logic signed [DATA_SIZE-1:0] mac_data;
    logic signed [DATA_SIZE-1:0] mac_result;
    logic                        coef_write;

    // A trigger in IDLE always wins over a simultaneous write; the extra bit
    // keeps the range check correct when 6*N_STAGES equals 2^ADDR_W.
    assign coef_write = bus.coef_we && (state_reg == IDLE) && !bus.sample_trig &&
                        ({1'b0, bus.coef_addr} < (ADDR_W + 1)'(N_COEFS));

    genvar gi;
    generate
        for (gi = 0; gi < N_COEFS; gi++) begin : g_coef
            localparam logic signed [COEF_SIZE-1:0] RESET_VAL =
                ((gi % N_COEF) == IDX_GAIN || (gi % N_COEF) == IDX_B0) ?
                COEF_SIZE'(coef_one(COEF_SIZE)) : '0;
            logic signed [COEF_SIZE-1:0] coef_reg;

            // Coefficient slot; resets to passthrough, writable only when idle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    coef_reg <= RESET_VAL;
                end else if (coef_write && bus.coef_addr == ADDR_W'(gi)) begin
                    coef_reg <= bus.coef_wdata;
                end
            end
            assign coef_arr[gi] = coef_reg;
        end

        for (gi = 0; gi < N_STAGES; gi++) begin : g_stage
            logic signed [DATA_SIZE-1:0] x1_reg;
            logic signed [DATA_SIZE-1:0] x2_reg;
            logic signed [DATA_SIZE-1:0] y1_reg;
            logic signed [DATA_SIZE-1:0] y2_reg;
            logic                        upd;

            assign upd = (state_reg == UPDATE) && (stage_reg == STAGE_W'(gi));

            // Per-stage history, shifted once when this stage finishes.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    x1_reg <= '0;
                    x2_reg <= '0;
                    y1_reg <= '0;
                    y2_reg <= '0;
                end else if (upd) begin
                    x2_reg <= x1_reg;
                    x1_reg <= x_cur_reg;
                    y2_reg <= y1_reg;
                    y1_reg <= mac_result;
                end
            end
            assign x1_arr[gi] = x1_reg;
            assign x2_arr[gi] = x2_reg;
            assign y1_arr[gi] = y1_reg;
            assign y2_arr[gi] = y2_reg;
        end
    endgenerate

    // Operand schedule. The B0 term is taken last: on MAC step 1 the
    // accumulator still holds GAIN*u, so x_s is captured from the rounded
    // output in parallel with the B1 product, keeping round/sat out of the
    // multiplier path.
    always_comb begin
        mac_op   = MAC_HOLD;
        coef_sel = 3'(IDX_GAIN);
        mac_data = u_reg;
        case (state_reg)
            GAIN: begin
                mac_op   = MAC_LOAD;
                coef_sel = 3'(IDX_GAIN);
                mac_data = u_reg;
            end
            MAC: begin
                case (idx_reg)
                    3'd1: begin
                        mac_op   = MAC_LOAD;
                        coef_sel = 3'(IDX_B1);
                        mac_data = x1_arr[stage_reg];
                    end
                    3'd2: begin
                        mac_op   = MAC_ADD;
                        coef_sel = 3'(IDX_B2);
                        mac_data = x2_arr[stage_reg];
                    end
                    3'd3: begin
                        mac_op   = MAC_SUB;
                        coef_sel = 3'(IDX_A1);
                        mac_data = y1_arr[stage_reg];
                    end
                    3'd4: begin
                        mac_op   = MAC_SUB;
                        coef_sel = 3'(IDX_A2);
                        mac_data = y2_arr[stage_reg];
                    end
                    default: begin
                        mac_op   = MAC_ADD;
                        coef_sel = 3'(IDX_B0);
                        mac_data = x_cur_reg;
                    end
                endcase
            end
            default: begin
                mac_op = MAC_HOLD;
            end
        endcase
    end

    assign coef_idx = CIDX_W'(stage_reg) * CIDX_W'(N_COEF) + CIDX_W'(coef_sel);
    assign coef_rd  = coef_arr[coef_idx];

    sos_mac #(
        .DATA_SIZE (DATA_SIZE),
        .COEF_SIZE (COEF_SIZE)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .op     (mac_op),
        .data   (mac_data),
        .coef   (coef_rd),
        .result (mac_result)
    );

    // Sequencer: walks every stage once per accepted trigger; all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            stage_reg       <= '0;
            idx_reg         <= '0;
            u_reg           <= '0;
            x_cur_reg       <= '0;
            data_out_reg    <= '0;
            filter_done_reg <= 1'b0;
            busy_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            overrun_reg     <= bus.sample_trig && busy_reg;
            filter_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.sample_trig) begin
                        u_reg     <= bus.data_in;
                        stage_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= GAIN;
                    end
                end
                GAIN: begin
                    idx_reg   <= 3'd1;
                    state_reg <= MAC;
                end
                MAC: begin
                    if (idx_reg == 3'd1) begin
                        x_cur_reg <= mac_result;
                    end
                    if (idx_reg == 3'd5) begin
                        state_reg <= UPDATE;
                    end else begin
                        idx_reg <= idx_reg + 3'd1;
                    end
                end
                UPDATE: begin
                    u_reg <= mac_result;
                    if (stage_reg == STAGE_W'(N_STAGES - 1)) begin
                        data_out_reg    <= mac_result;
                        filter_done_reg <= 1'b1;
                        state_reg       <= DONE;
                    end else begin
                        stage_reg <= stage_reg + STAGE_W'(1);
                        state_reg <= GAIN;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_out    = data_out_reg;
    assign bus.filter_done = filter_done_reg;
    assign bus.busy        = busy_reg;
    assign bus.overrun     = overrun_reg;
endmodule

// File: doc/iir_sos_cascade.md
# iir_sos_cascade

Parametrised successor to the single-stage high-pass section: a cascade of `N_STAGES` second-order IIR sections evaluated on one time-multiplexed multiply-accumulate unit. Coefficients can be reloaded at run time instead of being fixed at elaboration. It sits between the sample source and the output path. Each `sample_trig` starts one sample through every stage, and the block reports completion with a single-cycle `filter_done`.

## Interface

Parameters:
- `COEF_SIZE`, 20: signed coefficient width, format Q1.(COEF_SIZE-2), so 1.0 = 2^18.
- `DATA_SIZE`, 24: signed two's-complement sample width.
- `N_STAGES`, 4: number of cascaded SOS sections, range 1..16.
- `ADDR_W`, 7: coefficient address width; must be ≥ clog2(6·N_STAGES).

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all state.
- `data_in`, input, DATA_SIZE: input sample; captured in the cycle `sample_trig` is accepted.
- `sample_trig`, input, 1: start request; accepted only in IDLE.
- `data_out`, output, DATA_SIZE: last completed output; held between samples.
- `filter_done`, output, 1: one-cycle pulse when `data_out` updates.
- `busy`, output, 1: high from acceptance until the `filter_done` cycle inclusive.
- `overrun`, output, 1: one-cycle pulse when `sample_trig` arrives while `busy`.
- `coef_we`, input, 1: coefficient write strobe.
- `coef_addr`, input, ADDR_W: address = stage·6 + idx, with idx 0..5 = GAIN, B0, B1, B2, A1, A2.
- `coef_wdata`, input, COEF_SIZE: coefficient value.

## Operation

- **Reset values:** `data_out`=0, `filter_done`=0, `busy`=0, `overrun`=0, all delay lines 0.
- **Reset coefficients (passthrough):** GAIN=B0=2^(COEF_SIZE-2); B1=B2=A1=A2=0.
- **Section equation (Direct Form I, per stage s):**
  - x_s = sat(rnd(GAIN·u_s)).
  - y = sat(rnd(B0·x_s + B1·x1 + B2·x2 − A1·y1 − A2·y2)).
  - u_0 = `data_in`; u_{s+1} = y of stage s.
- **Rounding:** rnd adds 2^(COEF_SIZE-3), then arithmetic right shift by COEF_SIZE-2.
- **Saturation:** sat clamps to [−2^(DATA_SIZE-1), 2^(DATA_SIZE-1)−1].
- **Accumulator:** DATA_SIZE+COEF_SIZE+3 bits; no intermediate wrap.
- **Delay-line update (UPDATE cycle only):** x2←x1, x1←x_s, y2←y1, y1←y.
- **FSM states:** IDLE, GAIN, MAC, UPDATE, DONE.
  - IDLE→GAIN on `sample_trig`; latch `data_in`, stage=0.
  - GAIN→MAC: 1 cycle.
  - MAC: 5 cycles, idx 1..5.
  - MAC→UPDATE.
  - UPDATE→GAIN if stage<N_STAGES−1 (stage++); otherwise →DONE.
  - DONE: register `data_out`, pulse `filter_done`, →IDLE.
- **Coefficient writes:** applied in the same cycle when `busy`=0. Ignored when `busy`=1, when the address ≥ 6·N_STAGES, or in the cycle a trigger is accepted.
- **Simultaneous `coef_we` and accepted `sample_trig`:** trigger wins; the write is dropped.
- **`sample_trig` while busy:** ignored, `overrun` pulses; the sample in flight is unaffected.
- **Reset asserted mid-computation:** the sample is abandoned, all outputs/state return to reset values, no `filter_done`.

## Timing

- Trigger accepted at edge T. Stage s occupies edges T+1+7s … T+7+7s.
- DONE at edge T+7·N_STAGES+1: `data_out` valid and `filter_done`=1 in that cycle.
- Latency = 7·N_STAGES+1 cycles (29 for N_STAGES=4).
- Minimum trigger spacing = 7·N_STAGES+2 cycles. A trigger in the DONE cycle is an overrun; the next trigger is accepted the cycle after.
- Combinational path limit: one multiply plus accumulate per cycle.

## Structure

- Shared package `iir_pkg`:
  - coefficient index constants (IDX_GAIN … IDX_A2).
  - FSM state enum.
  - `sat`/`rnd` functions.
  - Q-format constant `COEF_ONE`.
- One sub-module `sos_mac`: signed multiply, accumulator with clear/load, round-and-saturate output.
- Top level holds:
  - FSM.
  - coefficient register file (6·N_STAGES × COEF_SIZE).
  - per-stage delay-line registers (4·N_STAGES × DATA_SIZE).

## Test plan

- Reset passthrough, N_STAGES=4: `data_in`=0x123456 with trigger → `filter_done` exactly 29 cycles later, `data_out`=0x123456, `busy` high for 29 cycles.
- FIR, N_STAGES=1: B0=B1=B2=2^18, A=0. Impulse 1000 then zeros → outputs 1000, 1000, 1000, 0.
- Feedback, N_STAGES=1: B0=2^18, A1=−131072 (0xE0000). Step input 1024 → outputs 1024, 1536, 1792, 1920.
- Saturation: B0=B1=2^18. Two samples of 0x7FFFFF → second `data_out`=0x7FFFFF. Two samples of 0x800000 → second `data_out`=0x800000.
- Protocol:
  - Trigger 5 cycles after acceptance → `overrun` pulse; the original sample's result is unchanged.
  - `coef_we` while busy → coefficient unchanged.
  - Write to address 6·N_STAGES → no effect.
- Reset mid-MAC → `data_out`=0, no `filter_done`, coefficients back to passthrough. The next sample passes unchanged.
